// File: rtl/nes_ppu_pkg.sv
// Shared types and constants for the PPU nametable RAM.
// NAMETABLE_FOUR_SCREEN_EN selects 4 physical banks instead of 2.
package nes_ppu_pkg;

   typedef enum logic [1:0] {
      MIR_HORZ  = 2'd0,
      MIR_VERT  = 2'd1,
      MIR_ONE_A = 2'd2,
      MIR_ONE_B = 2'd3
   } mirror_mode_e;

   typedef enum logic {
      NT_IDLE  = 1'b0,
      NT_CLEAR = 1'b1
   } nt_clr_state_e;

   localparam int NT_BANK_AW = 10;
   localparam int NT_ADDR_W  = 12;

`ifdef NAMETABLE_FOUR_SCREEN_EN
   localparam int NT_NUM_BANKS = 4;
`else
   localparam int NT_NUM_BANKS = 2;
`endif

endpackage

// File: rtl/nt_addr_map.sv
// Combinational logical-nametable to physical-bank address mapping.
// The four_screen input only matters when NAMETABLE_FOUR_SCREEN_EN widens BANK_W.
module nt_addr_map
   import nes_ppu_pkg::*;
#(
   parameter int BANK_AW = NT_BANK_AW,
   parameter int ADDR_W  = NT_ADDR_W,
   parameter int BANK_W  = 1
) (
   input  mirror_mode_e              mirror_mode,
   input  logic                      four_screen,
   input  logic [ADDR_W-1:0]         addr,
   output logic [BANK_W+BANK_AW-1:0] phys
);

   logic [1:0]        tbl;
   logic [BANK_W-1:0] bank;

   assign tbl = addr[BANK_AW+1:BANK_AW];

   always_comb begin
      bank = '0;
      if (four_screen) begin
         bank = BANK_W'(tbl);
      end else begin
         unique case (mirror_mode)
            MIR_HORZ:  bank = BANK_W'(tbl[1]);
            MIR_VERT:  bank = BANK_W'(tbl[0]);
            MIR_ONE_A: bank = '0;
            MIR_ONE_B: bank = BANK_W'(1);
            default:   bank = '0;
         endcase
      end
   end

   assign phys = {bank, addr[BANK_AW-1:0]};

endmodule

// File: rtl/nametable_ram.sv
// PPU nametable RAM: PPU-priority read port, CPU req/ack port and a zero-fill engine.
// Defining NAMETABLE_FOUR_SCREEN_EN adds the four_screen input and a 4-bank array.
module nametable_ram
   import nes_ppu_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int BANK_AW = NT_BANK_AW,
   parameter int ADDR_W  = NT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  mirror_mode_e      mirror_mode,
`ifdef NAMETABLE_FOUR_SCREEN_EN
   input  logic              four_screen,
`endif
   input  logic              ppu_rd,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic [DATA_W-1:0] ppu_rdata,
   output logic              ppu_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              clr_start,
   output logic              clr_busy
);

   localparam int NUM_BANKS = NT_NUM_BANKS;
   localparam int BANK_W    = $clog2(NUM_BANKS);
   localparam int PHYS_W    = BANK_W + BANK_AW;
   localparam int NUM_WORDS = NUM_BANKS << BANK_AW;

   logic [DATA_W-1:0] mem [NUM_WORDS];

   nt_clr_state_e     state_q, state_d;
   logic [PHYS_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [PHYS_W-1:0] ppu_phys, cpu_phys;
   logic              four_screen_s;
   logic              ppu_go, cpu_go, clr_we;
   logic [DATA_W-1:0] ppu_rdata_q, cpu_rdata_q;
   logic              ppu_rvalid_q, cpu_ack_q;

`ifdef NAMETABLE_FOUR_SCREEN_EN
   assign four_screen_s = four_screen;
`else
   assign four_screen_s = 1'b0;
`endif

   nt_addr_map #(.BANK_AW(BANK_AW), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) u_ppu_map (
      .mirror_mode (mirror_mode),
      .four_screen (four_screen_s),
      .addr        (ppu_addr),
      .phys        (ppu_phys)
   );

   nt_addr_map #(.BANK_AW(BANK_AW), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) u_cpu_map (
      .mirror_mode (mirror_mode),
      .four_screen (four_screen_s),
      .addr        (cpu_addr),
      .phys        (cpu_phys)
   );

   // The single RAM port is granted to the clear engine, then PPU, then CPU.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ppu_go    = 1'b0;
      cpu_go    = 1'b0;
      clr_we    = 1'b0;
      unique case (state_q)
         NT_IDLE: begin
            ppu_go = ppu_rd;
            cpu_go = cpu_req & ~ppu_rd;
            if (clr_start) begin
               state_d   = NT_CLEAR;
               clr_cnt_d = '0;
            end
         end
         NT_CLEAR: begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + PHYS_W'(1);
            if (clr_cnt_q == '1) state_d = NT_IDLE;
         end
         default: state_d = NT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= NT_IDLE;
         clr_cnt_q    <= '0;
         ppu_rvalid_q <= 1'b0;
         ppu_rdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         ppu_rvalid_q <= ppu_rd;
         if (ppu_go)             ppu_rdata_q <= mem[ppu_phys];
         else if (ppu_rd)        ppu_rdata_q <= '0;
         cpu_ack_q    <= cpu_go;
         if (cpu_go && !cpu_we)  cpu_rdata_q <= mem[cpu_phys];
      end
   end

   // RAM contents are deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (clr_we)                 mem[clr_cnt_q] <= '0;
      else if (cpu_go && cpu_we)  mem[cpu_phys]  <= cpu_wdata;
   end

   assign ppu_rdata  = ppu_rdata_q;
   assign ppu_rvalid = ppu_rvalid_q;
   assign cpu_ack    = cpu_ack_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign clr_busy   = (state_q == NT_CLEAR);

endmodule

// File: tb/tb_nametable_ram.sv
// Self-checking bench for nametable_ram with a logical-address reference model.
// Honours NAMETABLE_FOUR_SCREEN_EN to exercise the four-screen build.
module tb_nametable_ram;
   import nes_ppu_pkg::*;

`ifdef NAMETABLE_FOUR_SCREEN_EN
   localparam int NUM_WORDS = 4096;
`else
   localparam int NUM_WORDS = 2048;
`endif

   logic         clk = 1'b0;
   logic         reset_n;
   mirror_mode_e mirror_mode;
`ifdef NAMETABLE_FOUR_SCREEN_EN
   logic         four_screen;
`endif
   logic         ppu_rd;
   logic [11:0]  ppu_addr;
   logic [7:0]   ppu_rdata;
   logic         ppu_rvalid;
   logic         cpu_req, cpu_we;
   logic [11:0]  cpu_addr;
   logic [7:0]   cpu_wdata;
   logic         cpu_ack;
   logic [7:0]   cpu_rdata;
   logic         clr_start, clr_busy;

   int checks = 0;
   int errors = 0;
   int ref_mem [4096];
   bit fs_model = 1'b0;

   nametable_ram dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mirror_mode (mirror_mode),
`ifdef NAMETABLE_FOUR_SCREEN_EN
      .four_screen (four_screen),
`endif
      .ppu_rd      (ppu_rd),
      .ppu_addr    (ppu_addr),
      .ppu_rdata   (ppu_rdata),
      .ppu_rvalid  (ppu_rvalid),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .clr_start   (clr_start),
      .clr_busy    (clr_busy)
   );

   always #5 clk = ~clk;

   // Reference mapping: which 1 KiB physical bank a logical table lands in.
   function automatic int phys_of(input int mode, input int addr, input bit fs);
      int t, bank;
      t = (addr / 1024) % 4;
      if (fs) bank = t;
      else if (mode == 0) bank = t / 2;
      else if (mode == 1) bank = t % 2;
      else if (mode == 2) bank = 0;
      else bank = 1;
      return bank * 1024 + (addr % 1024);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_access(input bit we, input int addr, input int wd, output int rd);
      int n = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = 12'(addr); cpu_wdata = 8'(wd);
      tick();
      while (cpu_ack !== 1'b1 && n < 50) begin tick(); n++; end
      if (cpu_ack !== 1'b1) begin
         errors++; checks++;
         $display("FAIL cpu_timeout addr=%h got no ack required ack", addr);
      end
      rd = int'(cpu_rdata);
      cpu_req = 1'b0;
   endtask

   task automatic ppu_read(input int addr, output int data, output bit vld);
      ppu_rd = 1'b1; ppu_addr = 12'(addr);
      tick();
      data = int'(ppu_rdata); vld = ppu_rvalid;
      ppu_rd = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      tick(); tick();
      checks += 5;
      if (ppu_rdata !== 8'h00) begin errors++; $display("FAIL reset_ppu_rdata got %h required 00", ppu_rdata); end
      if (ppu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ppu_rvalid got %b required 0", ppu_rvalid); end
      if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata got %h required 00", cpu_rdata); end
      if (cpu_ack !== 1'b0)    begin errors++; $display("FAIL reset_cpu_ack got %b required 0", cpu_ack); end
      if (clr_busy !== 1'b0)   begin errors++; $display("FAIL reset_clr_busy got %b required 0", clr_busy); end
      #2 reset_n = 1'b1;
      tick();
   endtask

   task automatic test_clear();
      int busy = 0;
      int early = 0;
      int probe = 12'h000;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h000;
      while (clr_busy === 1'b1 && busy < NUM_WORDS + 20) begin
         busy++;
         if (cpu_ack === 1'b1) early++;
         ppu_rd = (busy == 10); ppu_addr = 12'(probe);
         clr_start = (busy == 50);
         tick();
         clr_start = 1'b0;
         if (busy == 10) begin
            checks++;
            if (ppu_rvalid !== 1'b1 || ppu_rdata !== 8'h00) begin
               errors++;
               $display("FAIL clear_ppu_read got vld=%b data=%h required vld=1 data=00", ppu_rvalid, ppu_rdata);
            end
         end
         ppu_rd = 1'b0;
      end
      if (cpu_ack === 1'b1) early++;
      checks += 4;
      if (busy != NUM_WORDS) begin errors++; $display("FAIL clear_busy_len got %0d required %0d", busy, NUM_WORDS); end
      if (early != 0) begin errors++; $display("FAIL clear_cpu_stall got %0d acks required 0", early); end
      tick();
      if (cpu_ack !== 1'b1) begin errors++; $display("FAIL clear_cpu_ack_after got %b required 1", cpu_ack); end
      if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL clear_cpu_rdata got %h required 00", cpu_rdata); end
      cpu_req = 1'b0;
      tick();
      for (int i = 0; i < 4096; i++) ref_mem[i] = 0;
      for (int i = 0; i < 6; i++) begin
         int a, d; bit v;
         a = $urandom_range(0, 4095);
         ppu_read(a, d, v);
         checks++;
         if (v !== 1'b1 || d != 0) begin errors++; $display("FAIL clear_zero addr=%h got vld=%b data=%h required vld=1 data=00", a, v, d); end
      end
   endtask

   task automatic test_vert();
      int rd, d; bit v;
      mirror_mode = MIR_VERT;
      cpu_access(1'b1, 12'h000, 8'h5A, rd);
      ref_mem[phys_of(1, 12'h000, fs_model)] = 8'h5A;
      ppu_read(12'h800, d, v);
      checks++;
      if (v !== 1'b1 || d != 8'h5A) begin errors++; $display("FAIL vert_alias got vld=%b data=%h required vld=1 data=5a", v, d); end
      ppu_read(12'h400, d, v);
      checks++;
      if (d == 8'h5A || d != ref_mem[phys_of(1, 12'h400, fs_model)]) begin
         errors++; $display("FAIL vert_distinct got %h required %h", d, ref_mem[phys_of(1, 12'h400, fs_model)]);
      end
   endtask

   task automatic test_horz_oneb();
      int rd, d; bit v;
      mirror_mode = MIR_HORZ;
      cpu_access(1'b1, 12'h000, 8'hC3, rd);
      ref_mem[phys_of(0, 12'h000, fs_model)] = 8'hC3;
      ppu_read(12'h400, d, v);
      checks++;
      if (d != 8'hC3) begin errors++; $display("FAIL horz_alias got %h required c3", d); end
      mirror_mode = MIR_ONE_B;
      cpu_access(1'b1, 12'h000, 8'h96, rd);
      ref_mem[phys_of(3, 12'h000, fs_model)] = 8'h96;
      ppu_read(12'hC00, d, v);
      checks++;
      if (d != 8'h96) begin errors++; $display("FAIL oneb_alias got %h required 96", d); end
   endtask

   task automatic test_ppu_priority();
      int rd;
      mirror_mode = MIR_ONE_A;
      cpu_access(1'b1, 12'h055, 8'h3C, rd);
      ref_mem[phys_of(2, 12'h055, fs_model)] = 8'h3C;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h055;
      ppu_rd = 1'b1; ppu_addr = 12'h055;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (cpu_ack !== 1'b0 || ppu_rvalid !== 1'b1) begin
            errors++; $display("FAIL prio_stall cycle=%0d got ack=%b vld=%b required ack=0 vld=1", i, cpu_ack, ppu_rvalid);
         end
      end
      ppu_rd = 1'b0;
      tick();
      checks += 2;
      if (cpu_ack !== 1'b1 || ppu_rvalid !== 1'b0) begin
         errors++; $display("FAIL prio_ack got ack=%b vld=%b required ack=1 vld=0", cpu_ack, ppu_rvalid);
      end
      if (cpu_rdata !== 8'h3C) begin errors++; $display("FAIL prio_rdata got %h required 3c", cpu_rdata); end
      cpu_req = 1'b0;
      tick();
      checks++;
      if (cpu_ack !== 1'b0) begin errors++; $display("FAIL prio_ack_pulse got %b required 0", cpu_ack); end
   endtask

   task automatic test_back_to_back();
      mirror_mode = MIR_VERT;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'hE7;
      tick();
      ref_mem[phys_of(1, 12'h123, fs_model)] = 8'hE7;
      checks++;
      if (cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack got %b required 1", cpu_ack); end
      cpu_req = 1'b0; ppu_rd = 1'b1; ppu_addr = 12'h923;
      tick();
      ppu_rd = 1'b0;
      checks++;
      if (ppu_rvalid !== 1'b1 || ppu_rdata !== 8'hE7) begin
         errors++; $display("FAIL b2b_visible got vld=%b data=%h required vld=1 data=e7", ppu_rvalid, ppu_rdata);
      end
      tick();
      checks++;
      if (ppu_rvalid !== 1'b0 || ppu_rdata !== 8'hE7) begin
         errors++; $display("FAIL b2b_hold got vld=%b data=%h required vld=0 data=e7", ppu_rvalid, ppu_rdata);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int m, a, d, rd, exp, op; bit v;
         m = $urandom_range(0, 3);
         mirror_mode = mirror_mode_e'(m);
`ifdef NAMETABLE_FOUR_SCREEN_EN
         fs_model = 1'($urandom_range(0, 1));
         four_screen = fs_model;
`endif
         a = $urandom_range(0, 3) * 1024 + $urandom_range(0, 7);
         op = $urandom_range(0, 2);
         exp = ref_mem[phys_of(m, a, fs_model)];
         if (op == 0) begin
            d = $urandom_range(0, 255);
            cpu_access(1'b1, a, d, rd);
            ref_mem[phys_of(m, a, fs_model)] = d;
         end else if (op == 1) begin
            cpu_access(1'b0, a, 0, rd);
            checks++;
            if (rd != exp) begin errors++; $display("FAIL rand_cpu_rd i=%0d addr=%h mode=%0d got %h required %h", i, a, m, rd, exp); end
         end else begin
            ppu_read(a, d, v);
            checks++;
            if (v !== 1'b1 || d != exp) begin
               errors++; $display("FAIL rand_ppu_rd i=%0d addr=%h mode=%0d got vld=%b data=%h required %h", i, a, m, v, d, exp);
            end
         end
      end
      fs_model = 1'b0;
`ifdef NAMETABLE_FOUR_SCREEN_EN
      four_screen = 1'b0;
`endif
   endtask

   task automatic test_reset_mid_clear();
      int rd, d, busy; bit v;
      mirror_mode = MIR_HORZ;
      cpu_access(1'b1, 12'h010, 8'hA5, rd);
      cpu_access(1'b0, 12'h010, 0, rd);
      ppu_read(12'h010, d, v);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      checks++;
      if (clr_busy !== 1'b1) begin errors++; $display("FAIL midclr_busy_before got %b required 1", clr_busy); end
      reset_n = 1'b0;
      #1;
      checks += 4;
      if (clr_busy !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b required 0", clr_busy); end
      if (ppu_rdata !== 8'h00) begin errors++; $display("FAIL midclr_ppu_rdata got %h required 00", ppu_rdata); end
      if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL midclr_cpu_rdata got %h required 00", cpu_rdata); end
      if (ppu_rvalid !== 1'b0 || cpu_ack !== 1'b0) begin
         errors++; $display("FAIL midclr_strobes got vld=%b ack=%b required 0 0", ppu_rvalid, cpu_ack);
      end
      tick();
      #2 reset_n = 1'b1;
      tick();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      busy = 0;
      while (clr_busy === 1'b1 && busy < NUM_WORDS + 20) begin busy++; tick(); end
      checks++;
      if (busy != NUM_WORDS) begin errors++; $display("FAIL midclr_restart_len got %0d required %0d", busy, NUM_WORDS); end
      for (int i = 0; i < 4096; i++) ref_mem[i] = 0;
      ppu_read(12'h010, d, v);
      checks++;
      if (d != 0) begin errors++; $display("FAIL midclr_zero got %h required 00", d); end
   endtask

`ifdef NAMETABLE_FOUR_SCREEN_EN
   task automatic test_four_screen();
      int rd, d; bit v;
      four_screen = 1'b1;
      mirror_mode = MIR_ONE_A;
      for (int t = 0; t < 4; t++) cpu_access(1'b1, t * 1024, 8'h10 + t, rd);
      for (int t = 0; t < 4; t++) begin
         ppu_read(t * 1024, d, v);
         checks++;
         if (d != 8'h10 + t) begin errors++; $display("FAIL four_screen t=%0d got %h required %h", t, d, 8'h10 + t); end
      end
      four_screen = 1'b0;
   endtask
`endif

   initial begin
      reset_n = 1'b1; mirror_mode = MIR_HORZ;
`ifdef NAMETABLE_FOUR_SCREEN_EN
      four_screen = 1'b0;
`endif
      ppu_rd = 1'b0; ppu_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      clr_start = 1'b0;
      test_reset();
      test_clear();
      test_vert();
      test_horz_oneb();
      test_ppu_priority();
      test_back_to_back();
      test_random();
      test_clear();
      test_reset_mid_clear();
`ifdef NAMETABLE_FOUR_SCREEN_EN
      test_four_screen();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
